// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-requester SRAM port arbiter.
// Requester 0 is the Wishbone host path and requester 1 is the secure-memory engine.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_RESP = 2'd2
  } port_st_t;

  localparam int NREQ     = 2;
  localparam int REQ_HOST = 0;
  localparam int REQ_SEC  = 1;

  // Converts a one-hot two-way grant into the index of the winning requester.
  function automatic logic gnt_to_idx(input logic [NREQ-1:0] gnt);
    return gnt[REQ_SEC] && !gnt[REQ_HOST];
  endfunction

endpackage

// File: rtl/sram_rr_arb2.sv
// Two-way round-robin picker: a lone requester always wins, and on a tie the
// requester that was not granted last wins. The pointer moves only when a grant is taken.
module sram_rr_arb2
  import sram_arb_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [NREQ-1:0] i_req,
  input  logic            i_advance,
  output logic [NREQ-1:0] o_gnt
);

  logic r_favourSec;

  always_comb begin
    o_gnt = i_req;
    if (&i_req) begin
      o_gnt = r_favourSec ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_favourSec <= 1'b0;
    end else if (i_advance && |o_gnt) begin
      r_favourSec <= o_gnt[REQ_HOST];
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares a 1rw1r SRAM macro between the host path and the secure engine:
// reads go to port A, writes to port B, each with its own arbiter and IDLE->CMD->RESP sequencer.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int SRAM_ADDR_WD = 8,
  parameter int SRAM_DATA_WD = 32
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_i,

  input  logic                      r0_req_i,
  input  logic                      r0_we_i,
  input  logic [SRAM_ADDR_WD-1:0]   r0_adr_i,
  input  logic [SRAM_DATA_WD-1:0]   r0_dat_i,
  input  logic [SRAM_DATA_WD/8-1:0] r0_sel_i,
  output logic                      r0_ack_o,
  output logic [SRAM_DATA_WD-1:0]   r0_dat_o,

  input  logic                      r1_req_i,
  input  logic                      r1_we_i,
  input  logic [SRAM_ADDR_WD-1:0]   r1_adr_i,
  input  logic [SRAM_DATA_WD-1:0]   r1_dat_i,
  input  logic [SRAM_DATA_WD/8-1:0] r1_sel_i,
  output logic                      r1_ack_o,
  output logic [SRAM_DATA_WD-1:0]   r1_dat_o,

  output logic                      sram_csb_a,
  output logic [SRAM_ADDR_WD-1:0]   sram_addr_a,
  input  logic [SRAM_DATA_WD-1:0]   sram_dout_a,

  output logic                      sram_csb_b,
  output logic                      sram_web_b,
  output logic [SRAM_DATA_WD/8-1:0] sram_mask_b,
  output logic [SRAM_ADDR_WD-1:0]   sram_addr_b,
  output logic [SRAM_DATA_WD-1:0]   sram_din_b
);

  localparam int AW = SRAM_ADDR_WD;
  localparam int DW = SRAM_DATA_WD;
  localparam int SW = SRAM_DATA_WD / 8;

  logic [NREQ-1:0]         w_req;
  logic [NREQ-1:0]         w_we;
  logic [NREQ-1:0][AW-1:0] w_adr;
  logic [NREQ-1:0][DW-1:0] w_dat;
  logic [NREQ-1:0][SW-1:0] w_sel;

  assign w_req = {r1_req_i, r0_req_i};
  assign w_we  = {r1_we_i, r0_we_i};
  assign w_adr = {r1_adr_i, r0_adr_i};
  assign w_dat = {r1_dat_i, r0_dat_i};
  assign w_sel = {r1_sel_i, r0_sel_i};

  port_st_t r_rdState, w_rdStateNxt;
  port_st_t r_wrState, w_wrStateNxt;
  logic     r_rdOwner, w_rdOwnerNxt;
  logic     r_wrOwner, w_wrOwnerNxt;

  logic          r_csbA, w_csbANxt;
  logic [AW-1:0] r_addrA, w_addrANxt;
  logic          r_csbB, w_csbBNxt;
  logic          r_webB, w_webBNxt;
  logic [SW-1:0] r_maskB, w_maskBNxt;
  logic [AW-1:0] r_addrB, w_addrBNxt;
  logic [DW-1:0] r_dinB, w_dinBNxt;

  logic [NREQ-1:0] w_busy;
  logic [NREQ-1:0] w_rdElig;
  logic [NREQ-1:0] w_wrElig;
  logic [NREQ-1:0] w_rdGnt;
  logic [NREQ-1:0] w_wrGnt;
  logic            w_rdPick;
  logic            w_wrPick;
  logic            w_rdGo;
  logic            w_wrGo;
  logic            w_hazard;

  // A requester that already owns an in-flight op on either port cannot start another.
  always_comb begin
    w_busy = '0;
    for (int n = 0; n < NREQ; n++) begin
      w_busy[n] = ((r_rdState != ST_IDLE) && (r_rdOwner == 1'(n))) ||
                  ((r_wrState != ST_IDLE) && (r_wrOwner == 1'(n)));
    end
  end

  assign w_rdElig = w_req & ~w_we & ~w_busy;
  assign w_wrElig = w_req &  w_we & ~w_busy;

  sram_rr_arb2 u_rdArb (
    .i_clk     (wb_clk_i),
    .i_rst     (wb_rst_i),
    .i_req     (w_rdElig),
    .i_advance (w_rdGo),
    .o_gnt     (w_rdGnt)
  );

  sram_rr_arb2 u_wrArb (
    .i_clk     (wb_clk_i),
    .i_rst     (wb_rst_i),
    .i_req     (w_wrElig),
    .i_advance (w_wrGo),
    .o_gnt     (w_wrGnt)
  );

  assign w_rdPick = gnt_to_idx(w_rdGnt);
  assign w_wrPick = gnt_to_idx(w_wrGnt);

  // Holding the read back one cycle makes it capture after the write has landed.
  assign w_wrGo   = (r_wrState == ST_IDLE) && |w_wrGnt;
  assign w_hazard = w_wrGo && (w_adr[w_rdPick] == w_adr[w_wrPick]);
  assign w_rdGo   = (r_rdState == ST_IDLE) && |w_rdGnt && !w_hazard;

  always_comb begin
    w_rdStateNxt = r_rdState;
    w_rdOwnerNxt = r_rdOwner;
    w_csbANxt    = 1'b1;
    w_addrANxt   = r_addrA;
    case (r_rdState)
      ST_IDLE: begin
        if (w_rdGo) begin
          w_rdStateNxt = ST_CMD;
          w_rdOwnerNxt = w_rdPick;
          w_csbANxt    = 1'b0;
          w_addrANxt   = w_adr[w_rdPick];
        end
      end
      ST_CMD:  w_rdStateNxt = ST_RESP;
      ST_RESP: w_rdStateNxt = ST_IDLE;
      default: w_rdStateNxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_wrStateNxt = r_wrState;
    w_wrOwnerNxt = r_wrOwner;
    w_csbBNxt    = 1'b1;
    w_webBNxt    = 1'b1;
    w_maskBNxt   = r_maskB;
    w_addrBNxt   = r_addrB;
    w_dinBNxt    = r_dinB;
    case (r_wrState)
      ST_IDLE: begin
        if (w_wrGo) begin
          w_wrStateNxt = ST_CMD;
          w_wrOwnerNxt = w_wrPick;
          w_csbBNxt    = 1'b0;
          w_webBNxt    = 1'b0;
          w_maskBNxt   = w_sel[w_wrPick];
          w_addrBNxt   = w_adr[w_wrPick];
          w_dinBNxt    = w_dat[w_wrPick];
        end
      end
      ST_CMD:  w_wrStateNxt = ST_RESP;
      ST_RESP: w_wrStateNxt = ST_IDLE;
      default: w_wrStateNxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_rdState <= ST_IDLE;
      r_rdOwner <= 1'b0;
      r_csbA    <= 1'b1;
      r_addrA   <= '0;
      r_wrState <= ST_IDLE;
      r_wrOwner <= 1'b0;
      r_csbB    <= 1'b1;
      r_webB    <= 1'b1;
      r_maskB   <= '0;
      r_addrB   <= '0;
      r_dinB    <= '0;
    end else begin
      r_rdState <= w_rdStateNxt;
      r_rdOwner <= w_rdOwnerNxt;
      r_csbA    <= w_csbANxt;
      r_addrA   <= w_addrANxt;
      r_wrState <= w_wrStateNxt;
      r_wrOwner <= w_wrOwnerNxt;
      r_csbB    <= w_csbBNxt;
      r_webB    <= w_webBNxt;
      r_maskB   <= w_maskBNxt;
      r_addrB   <= w_addrBNxt;
      r_dinB    <= w_dinBNxt;
    end
  end

  assign sram_csb_a  = r_csbA;
  assign sram_addr_a = r_addrA;
  assign sram_csb_b  = r_csbB;
  assign sram_web_b  = r_webB;
  assign sram_mask_b = r_maskB;
  assign sram_addr_b = r_addrB;
  assign sram_din_b  = r_dinB;

  // Read data arrives from the macro during RESP, so it is steered straight through to the owner.
  assign r0_ack_o = ((r_rdState == ST_RESP) && (r_rdOwner == 1'(REQ_HOST))) ||
                    ((r_wrState == ST_RESP) && (r_wrOwner == 1'(REQ_HOST)));
  assign r1_ack_o = ((r_rdState == ST_RESP) && (r_rdOwner == 1'(REQ_SEC))) ||
                    ((r_wrState == ST_RESP) && (r_wrOwner == 1'(REQ_SEC)));

  assign r0_dat_o = ((r_rdState == ST_RESP) && (r_rdOwner == 1'(REQ_HOST))) ? sram_dout_a : '0;
  assign r1_dat_o = ((r_rdState == ST_RESP) && (r_rdOwner == 1'(REQ_SEC)))  ? sram_dout_a : '0;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a behavioural 1rw1r SRAM model.
// Inputs are driven and outputs sampled on the falling edge.
module tb_sram_port_arbiter;
  import sram_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        r0Req, r0We, r1Req, r1We;
  logic [7:0]  r0Adr, r1Adr;
  logic [31:0] r0Dat, r1Dat;
  logic [3:0]  r0Sel, r1Sel;
  logic        r0Ack, r1Ack;
  logic [31:0] r0DatO, r1DatO;
  logic        csbA, csbB, webB;
  logic [7:0]  addrA, addrB;
  logic [31:0] doutA, dinB;
  logic [3:0]  maskB;
  logic [31:0] mem [256];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram_port_arbiter dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .r0_req_i(r0Req), .r0_we_i(r0We), .r0_adr_i(r0Adr), .r0_dat_i(r0Dat), .r0_sel_i(r0Sel),
    .r0_ack_o(r0Ack), .r0_dat_o(r0DatO),
    .r1_req_i(r1Req), .r1_we_i(r1We), .r1_adr_i(r1Adr), .r1_dat_i(r1Dat), .r1_sel_i(r1Sel),
    .r1_ack_o(r1Ack), .r1_dat_o(r1DatO),
    .sram_csb_a(csbA), .sram_addr_a(addrA), .sram_dout_a(doutA),
    .sram_csb_b(csbB), .sram_web_b(webB), .sram_mask_b(maskB), .sram_addr_b(addrB), .sram_din_b(dinB)
  );

  // SRAM model: port A reads before port B writes on a shared edge, like a real macro would.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 | i;
      doutA <= '0;
    end else begin
      if (!csbA) doutA <= mem[addrA];
      if (!csbB && !webB) begin
        for (int b = 0; b < 4; b++) if (maskB[b]) mem[addrB][8*b +: 8] = dinB[8*b +: 8];
      end
    end
  end

  task automatic applyStimulus(input int n, input logic req, input logic we, input logic [7:0] adr,
                               input logic [31:0] dat, input logic [3:0] sel);
    if (n == 0) begin
      r0Req = req; r0We = we; r0Adr = adr; r0Dat = dat; r0Sel = sel;
    end else begin
      r1Req = req; r1We = we; r1Adr = adr; r1Dat = dat; r1Sel = sel;
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    applyStimulus(0, 1'b1, 1'b1, 8'h30, 32'h0102_0304, 4'hF);
    tick();
    checks++; if (csbB !== 1'b0) begin errors++; $display("[TB] FAIL rst_prewrite_csb_b got %0h want 0", csbB); end
    rst = 1'b1;
    applyStimulus(0, 1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
    tick(); tick();
    rst = 1'b0;
    tick();
    checks++; if (csbA !== 1'b1) begin errors++; $display("[TB] FAIL rst_csb_a got %0h want 1", csbA); end
    checks++; if (csbB !== 1'b1) begin errors++; $display("[TB] FAIL rst_csb_b got %0h want 1", csbB); end
    checks++; if (webB !== 1'b1) begin errors++; $display("[TB] FAIL rst_web_b got %0h want 1", webB); end
    checks++; if (addrB !== 8'h00) begin errors++; $display("[TB] FAIL rst_addr_b got %0h want 0", addrB); end
    checks++; if (dinB !== 32'h0) begin errors++; $display("[TB] FAIL rst_din_b got %0h want 0", dinB); end
    checks++; if (maskB !== 4'h0) begin errors++; $display("[TB] FAIL rst_mask_b got %0h want 0", maskB); end
    checks++; if (dut.r_rdState !== ST_IDLE) begin errors++; $display("[TB] FAIL rst_rd_state got %0d want 0", dut.r_rdState); end
    checks++; if (dut.r_wrState !== ST_IDLE) begin errors++; $display("[TB] FAIL rst_wr_state got %0d want 0", dut.r_wrState); end
    for (int c = 0; c < 3; c++) begin
      checks++; if ({r0Ack, r1Ack} !== 2'b00) begin errors++; $display("[TB] FAIL rst_acks got %b want 00", {r0Ack, r1Ack}); end
      checks++; if (r0DatO !== 32'h0) begin errors++; $display("[TB] FAIL rst_r0_dat got %0h want 0", r0DatO); end
      tick();
    end
  endtask

  task automatic test_single_write();
    applyStimulus(0, 1'b1, 1'b1, 8'h10, 32'hDEAD_BEEF, 4'hF);
    tick();
    checks++; if ({csbB, webB} !== 2'b00) begin errors++; $display("[TB] FAIL wr_cmd_csb_web got %b want 00", {csbB, webB}); end
    checks++; if (addrB !== 8'h10) begin errors++; $display("[TB] FAIL wr_addr_b got %0h want 10", addrB); end
    checks++; if (dinB !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL wr_din_b got %0h want deadbeef", dinB); end
    checks++; if (maskB !== 4'hF) begin errors++; $display("[TB] FAIL wr_mask_b got %0h want f", maskB); end
    checks++; if (r0Ack !== 1'b0) begin errors++; $display("[TB] FAIL wr_early_ack got %0h want 0", r0Ack); end
    checks++; if (csbA !== 1'b1) begin errors++; $display("[TB] FAIL wr_csb_a got %0h want 1", csbA); end
    tick();
    checks++; if (r0Ack !== 1'b1) begin errors++; $display("[TB] FAIL wr_ack got %0h want 1", r0Ack); end
    checks++; if ({csbB, webB} !== 2'b11) begin errors++; $display("[TB] FAIL wr_resp_csb_web got %b want 11", {csbB, webB}); end
    applyStimulus(0, 1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
    tick();
    checks++; if (r0Ack !== 1'b0) begin errors++; $display("[TB] FAIL wr_ack_len got %0h want 0", r0Ack); end
  endtask

  task automatic test_single_read();
    applyStimulus(1, 1'b1, 1'b0, 8'h10, 32'h0, 4'h0);
    tick();
    checks++; if (csbA !== 1'b0) begin errors++; $display("[TB] FAIL rd_cmd_csb_a got %0h want 0", csbA); end
    checks++; if (addrA !== 8'h10) begin errors++; $display("[TB] FAIL rd_addr_a got %0h want 10", addrA); end
    checks++; if (csbB !== 1'b1) begin errors++; $display("[TB] FAIL rd_csb_b got %0h want 1", csbB); end
    tick();
    checks++; if (r1Ack !== 1'b1) begin errors++; $display("[TB] FAIL rd_ack got %0h want 1", r1Ack); end
    checks++; if (r1DatO !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL rd_dat got %0h want deadbeef", r1DatO); end
    checks++; if (r0DatO !== 32'h0) begin errors++; $display("[TB] FAIL rd_other_dat got %0h want 0", r0DatO); end
    checks++; if (r0Ack !== 1'b0) begin errors++; $display("[TB] FAIL rd_other_ack got %0h want 0", r0Ack); end
    applyStimulus(1, 1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
    tick();
    checks++; if (r1Ack !== 1'b0 || r1DatO !== 32'h0) begin errors++; $display("[TB] FAIL rd_after got ack %0h dat %0h want 0 0", r1Ack, r1DatO); end
  endtask

  task automatic test_contention();
    logic        e0, e1;
    applyStimulus(0, 1'b1, 1'b0, 8'h40, 32'h0, 4'h0);
    applyStimulus(1, 1'b1, 1'b0, 8'h41, 32'h0, 4'h0);
    for (int c = 1; c <= 12; c++) begin
      tick();
      e0 = (c == 2) || (c == 8);
      e1 = (c == 5) || (c == 11);
      checks++; if (r0Ack !== e0) begin errors++; $display("[TB] FAIL cont_r0_ack cyc %0d got %0h want %0h", c, r0Ack, e0); end
      checks++; if (r1Ack !== e1) begin errors++; $display("[TB] FAIL cont_r1_ack cyc %0d got %0h want %0h", c, r1Ack, e1); end
      checks++; if (r0DatO !== (e0 ? 32'hA500_0040 : 32'h0)) begin errors++; $display("[TB] FAIL cont_r0_dat cyc %0d got %0h", c, r0DatO); end
      checks++; if (r1DatO !== (e1 ? 32'hA500_0041 : 32'h0)) begin errors++; $display("[TB] FAIL cont_r1_dat cyc %0d got %0h", c, r1DatO); end
      checks++; if (csbA !== ((c % 3) != 1)) begin errors++; $display("[TB] FAIL cont_csb_a cyc %0d got %0h", c, csbA); end
    end
    applyStimulus(0, 1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
    applyStimulus(1, 1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
    tick();
  endtask

  task automatic test_parallel();
    applyStimulus(0, 1'b1, 1'b1, 8'h20, 32'hCAFE_F00D, 4'hF);
    applyStimulus(1, 1'b1, 1'b0, 8'h21, 32'h0, 4'h0);
    tick();
    checks++; if ({csbA, csbB} !== 2'b00) begin errors++; $display("[TB] FAIL par_csb got %b want 00", {csbA, csbB}); end
    checks++; if (addrA !== 8'h21 || addrB !== 8'h20) begin errors++; $display("[TB] FAIL par_addr got %0h/%0h want 21/20", addrA, addrB); end
    tick();
    checks++; if ({r0Ack, r1Ack} !== 2'b11) begin errors++; $display("[TB] FAIL par_acks got %b want 11", {r0Ack, r1Ack}); end
    checks++; if (r1DatO !== 32'hA500_0021) begin errors++; $display("[TB] FAIL par_dat got %0h want a5000021", r1DatO); end
    applyStimulus(0, 1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
    applyStimulus(1, 1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
    tick();
  endtask

  task automatic test_hazard();
    applyStimulus(0, 1'b1, 1'b1, 8'h20, 32'h1234_5678, 4'hF);
    applyStimulus(1, 1'b1, 1'b0, 8'h20, 32'h0, 4'h0);
    tick();
    checks++; if ({csbA, csbB} !== 2'b10) begin errors++; $display("[TB] FAIL haz_cmd_csb got %b want 10", {csbA, csbB}); end
    tick();
    checks++; if (r0Ack !== 1'b1) begin errors++; $display("[TB] FAIL haz_wr_ack got %0h want 1", r0Ack); end
    checks++; if (csbA !== 1'b0 || addrA !== 8'h20) begin errors++; $display("[TB] FAIL haz_rd_cmd got csb %0h addr %0h want 0 20", csbA, addrA); end
    checks++; if (r1Ack !== 1'b0) begin errors++; $display("[TB] FAIL haz_early_rd_ack got %0h want 0", r1Ack); end
    applyStimulus(0, 1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
    tick();
    checks++; if (r1Ack !== 1'b1) begin errors++; $display("[TB] FAIL haz_rd_ack got %0h want 1", r1Ack); end
    checks++; if (r1DatO !== 32'h1234_5678) begin errors++; $display("[TB] FAIL haz_rd_dat got %0h want 12345678", r1DatO); end
    applyStimulus(1, 1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
    tick();
  endtask

  task automatic test_write_contention();
    applyStimulus(0, 1'b1, 1'b1, 8'h50, 32'h0BAD_CAFE, 4'hF);
    applyStimulus(1, 1'b1, 1'b1, 8'h51, 32'hFEED_FACE, 4'hF);
    tick();
    checks++; if (addrB !== 8'h51 || dinB !== 32'hFEED_FACE) begin errors++; $display("[TB] FAIL wcont_first got %0h/%0h want 51/feedface", addrB, dinB); end
    tick();
    checks++; if ({r0Ack, r1Ack} !== 2'b01) begin errors++; $display("[TB] FAIL wcont_ack1 got %b want 01", {r0Ack, r1Ack}); end
    applyStimulus(1, 1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
    tick();
    checks++; if (csbB !== 1'b1) begin errors++; $display("[TB] FAIL wcont_gap_csb_b got %0h want 1", csbB); end
    tick();
    checks++; if (csbB !== 1'b0 || addrB !== 8'h50) begin errors++; $display("[TB] FAIL wcont_second got csb %0h addr %0h want 0 50", csbB, addrB); end
    tick();
    checks++; if ({r0Ack, r1Ack} !== 2'b10) begin errors++; $display("[TB] FAIL wcont_ack2 got %b want 10", {r0Ack, r1Ack}); end
    applyStimulus(0, 1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
    tick();
  endtask

  task automatic test_drop();
    int ackCount = 0;
    applyStimulus(0, 1'b1, 1'b0, 8'h41, 32'h0, 4'h0);
    tick();
    checks++; if (csbA !== 1'b0) begin errors++; $display("[TB] FAIL drop_cmd_csb_a got %0h want 0", csbA); end
    applyStimulus(0, 1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
    tick();
    checks++; if (r0DatO !== 32'hA500_0041) begin errors++; $display("[TB] FAIL drop_dat got %0h want a5000041", r0DatO); end
    for (int c = 0; c < 5; c++) begin
      if (r0Ack === 1'b1) ackCount++;
      checks++; if (c > 0 && csbA !== 1'b1) begin errors++; $display("[TB] FAIL drop_regrant cyc %0d got csb_a %0h want 1", c, csbA); end
      tick();
    end
    checks++; if (ackCount !== 1) begin errors++; $display("[TB] FAIL drop_ack_count got %0d want 1", ackCount); end
  endtask

  task automatic test_byte_mask();
    applyStimulus(0, 1'b1, 1'b1, 8'h10, 32'h1122_3344, 4'h3);
    tick();
    checks++; if (maskB !== 4'h3) begin errors++; $display("[TB] FAIL mask_b got %0h want 3", maskB); end
    tick();
    applyStimulus(0, 1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
    applyStimulus(1, 1'b1, 1'b0, 8'h10, 32'h0, 4'h0);
    tick(); tick();
    checks++; if (r1Ack !== 1'b1 || r1DatO !== 32'hDEAD_3344) begin errors++; $display("[TB] FAIL mask_readback got ack %0h dat %0h want 1 dead3344", r1Ack, r1DatO); end
    applyStimulus(1, 1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
    tick();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1;
    applyStimulus(0, 1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
    applyStimulus(1, 1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
    repeat (3) tick();
    rst = 1'b0;
    test_reset();
    test_single_write();
    test_single_read();
    test_contention();
    test_parallel();
    test_hazard();
    test_write_contention();
    test_drop();
    test_byte_mask();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
